// File: rtl/spi_slave_burst.sv
// SPI-style slave: command bit, address, then data words into an M x N register array.
// Define SPI_SLAVE_BURST_EN to stream word after word with address auto-increment.
module spi_slave_burst #(
   parameter int N = 8,
   parameter int M = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic CS,
   input  logic MISO,
   output logic MOSI,
   output logic busy,
   output logic err
);

   localparam int AW = $clog2(M);
   localparam int CW = $clog2(N + AW + 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t          state, state_next;
   logic            cmd;
   logic [AW-1:0]   addr;
   logic [CW-1:0]   cnt;
   logic [N-1:0]    shift;
   logic [N-1:0]    mem [M];

   logic [AW:0]     addr_cat;
   logic [AW-1:0]   addr_shifted;
   logic [N-1:0]    word_in;
   logic [N-1:0]    rd_shift;
   logic            last_addr_bit;
   logic            last_data_bit;
   logic            active;
   logic            mem_we;

   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < (AW+1)'(M);
   endfunction

   assign addr_cat      = {addr, MISO};
   assign addr_shifted  = addr_cat[AW-1:0];
   assign word_in       = {shift[N-2:0], MISO};
   assign last_addr_bit = (cnt == CW'(AW - 1));
   assign last_data_bit = (cnt == CW'(N - 1));
   assign rd_shift      = in_range(addr_shifted) ? mem[addr_shifted] : '0;

`ifdef SPI_SLAVE_BURST_EN
   logic [AW-1:0] addr_inc;
   logic [N-1:0]  rd_inc;

   assign active   = 1'b1;
   assign addr_inc = (addr == AW'(M - 1)) ? '0 : addr + 1'b1;
   assign rd_inc   = in_range(addr_inc) ? mem[addr_inc] : '0;
`else
   // Set after the single data word; the rest of the frame is ignored.
   logic done;

   assign active = ~done;
`endif

   assign mem_we = (state == DATA) && !CS && cmd && active && last_data_bit && in_range(addr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = (state != IDLE);
      MOSI       = 1'b0;
      if (CS) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    state_next = ADDR;
            ADDR:    if (last_addr_bit) state_next = DATA;
            DATA:    state_next = DATA;
            default: state_next = IDLE;
         endcase
      end
      if (state == DATA && !cmd && active) MOSI = shift[N-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd   <= 1'b0;
         addr  <= '0;
         cnt   <= '0;
         shift <= '0;
         err   <= 1'b0;
`ifndef SPI_SLAVE_BURST_EN
         done  <= 1'b0;
`endif
      end else if (CS) begin
         cnt   <= '0;
`ifndef SPI_SLAVE_BURST_EN
         done  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               cmd  <= MISO;
               addr <= '0;
               cnt  <= '0;
               err  <= 1'b0;
`ifndef SPI_SLAVE_BURST_EN
               done <= 1'b0;
`endif
            end
            ADDR: begin
               addr <= addr_shifted;
               if (last_addr_bit) begin
                  cnt <= '0;
                  if (!cmd) shift <= rd_shift;
                  if (!in_range(addr_shifted)) err <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (active) begin
                  if (last_data_bit) begin
                     cnt <= '0;
`ifdef SPI_SLAVE_BURST_EN
                     addr  <= addr_inc;
                     shift <= cmd ? word_in : rd_inc;
`else
                     done  <= 1'b1;
                     shift <= word_in;
`endif
                  end else begin
                     cnt   <= cnt + 1'b1;
                     shift <= word_in;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the array has no reset; only addressed words are ever written.
   always_ff @(posedge clk) begin
      if (mem_we) mem[addr] <= word_in;
   end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Scoreboard bench for spi_slave_burst: instances with M=32 and M=20 share one serial driver.
// Expected read words are queued by the stimulus and popped by a monitor that assembles MOSI.
module tb_spi_slave_burst;

   localparam int N  = 8;
   localparam int AW = 5;

   logic clk, rst, cs, miso, sel;
   logic mosi32, busy32, err32;
   logic mosi20, busy20, err20;
   logic mosi_m, busy_m, err_m;

   int errors = 0;
   int checks = 0;
   logic [N-1:0] exp_q [$];

   spi_slave_burst #(.N(N), .M(32)) dut32 (
      .clk(clk), .rst(rst), .CS(sel ? 1'b1 : cs), .MISO(miso),
      .MOSI(mosi32), .busy(busy32), .err(err32)
   );

   spi_slave_burst #(.N(N), .M(20)) dut20 (
      .clk(clk), .rst(rst), .CS(sel ? cs : 1'b1), .MISO(miso),
      .MOSI(mosi20), .busy(busy20), .err(err20)
   );

   assign mosi_m = sel ? mosi20 : mosi32;
   assign busy_m = sel ? busy20 : busy32;
   assign err_m  = sel ? err20  : err32;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      cs   = 1'b0;
      miso = b;
   endtask

   task automatic send_hdr(input logic c, input logic [AW-1:0] a);
      send_bit(c);
      for (int i = AW - 1; i >= 0; i--) send_bit(a[i]);
   endtask

   task automatic send_byte(input logic [N-1:0] d);
      for (int i = N - 1; i >= 0; i--) send_bit(d[i]);
   endtask

   task automatic end_frame();
      @(negedge clk);
      cs   = 1'b1;
      miso = 1'b0;
      @(negedge clk);
   endtask

   task automatic wr1(input logic [AW-1:0] a, input logic [N-1:0] d);
      send_hdr(1'b1, a);
      send_byte(d);
      end_frame();
   endtask

   task automatic rd(input logic [AW-1:0] a, input int words, input logic [N-1:0] e0,
                     input logic [N-1:0] e1);
      exp_q.push_back(e0);
      if (words > 1) exp_q.push_back(e1);
      send_hdr(1'b0, a);
      repeat (words * N) send_bit(1'b0);
      end_frame();
   endtask

   // Monitor: counts CS-low edges, checks frame-start flags and assembles read words.
   initial begin
      int k = 0;
      int nb = 0;
      logic mcmd = 1'b0;
      logic cs_s, miso_s;
      logic [N-1:0] acc = '0;
      logic [N-1:0] e;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            k  = 0;
            nb = 0;
            continue;
         end
         cs_s   = cs;
         miso_s = miso;
         #1;
         if (cs_s) begin
            k  = 0;
            nb = 0;
         end else begin
            k++;
            check("busy_in_frame", busy_m, 1);
            if (k == 1) begin
               mcmd = miso_s;
               check("err_clear_at_start", err_m, 0);
            end else if (k >= AW + 1) begin
               if (mcmd) begin
                  check("mosi_zero_on_write", mosi_m, 0);
               end else begin
                  acc = {acc[N-2:0], mosi_m};
                  nb++;
                  if (nb == N) begin
                     nb = 0;
                     if (exp_q.size() == 0) begin
                        check("sb_underflow", exp_q.size(), 1);
                     end else begin
                        e = exp_q.pop_front();
                        check("rd_word", acc, e);
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      rst  = 1'b1;
      cs   = 1'b1;
      miso = 1'b0;
      sel  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy32, 0);
      check("rst_mosi", mosi32, 0);
      check("rst_err", err32, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single write of 0xA5 at 5, then read it back MSB first
      wr1(5'd5, 8'hA5);
      check("wr_err", err32, 0);
      rd(5'd5, 1, 8'hA5, 8'h00);

      // Two-word write at 31: wraps to 0 only in burst builds
      wr1(5'd0, 8'h5C);
      send_hdr(1'b1, 5'd31);
      send_byte(8'h11);
      send_byte(8'h22);
      end_frame();
`ifdef SPI_SLAVE_BURST_EN
      rd(5'd31, 2, 8'h11, 8'h22);
      rd(5'd0, 1, 8'h22, 8'h00);
`else
      rd(5'd31, 2, 8'h11, 8'h00);
      rd(5'd0, 1, 8'h5C, 8'h00);
`endif

      // Abort after 4 data bits leaves the word untouched
      wr1(5'd3, 8'h3C);
      send_hdr(1'b1, 5'd3);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      @(negedge clk);
      cs = 1'b1;
      @(negedge clk);
      check("abort_busy", busy32, 0);
      rd(5'd3, 1, 8'h3C, 8'h00);

      // Reset in the middle of a read of 0xA5 while MOSI is high
      send_hdr(1'b0, 5'd5);
      @(posedge clk);
      #2;
      check("mosi_pre_rst", mosi32, 1);
      rst = 1'b1;
      #1;
      check("rst_async_mosi", mosi32, 0);
      check("rst_async_busy", busy32, 0);
      @(negedge clk);
      cs = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // M=20 instance: out-of-range write is dropped and flags err
      sel = 1'b1;
      @(negedge clk);
      wr1(5'd5, 8'h77);
      wr1(5'd9, 8'h66);
      wr1(5'd25, 8'hEE);
      check("oor_err_set", err20, 1);
      rd(5'd25, 1, 8'h00, 8'h00);
      check("oor_rd_err", err20, 1);
      rd(5'd5, 1, 8'h77, 8'h00);
      check("valid_err_clear", err20, 0);
      rd(5'd9, 1, 8'h66, 8'h00);

      // Reset clears a set err immediately
      send_hdr(1'b0, 5'd25);
      @(posedge clk);
      #2;
      check("err_pre_rst", err20, 1);
      rst = 1'b1;
      #1;
      check("rst_async_err", err20, 0);
      check("rst_async_busy20", busy20, 0);
      @(negedge clk);
      cs = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rd(5'd5, 1, 8'h77, 8'h00);

      repeat (3) @(negedge clk);
      check("sb_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
